// File: rtl/pvt_sensor_pkg.sv
// Shared types for the VT-sensor ring-oscillator select path:
// sequencer state encoding and the wrapping channel-mask search.
package pvt_sensor_pkg;

    localparam int MAX_RO = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_SWITCH,
        S_SETTLE,
        S_ACTIVE
    } state_e;

    // First set bit at index >= start, wrapping within n (power of 2) channels.
    function automatic int next_set_bit(
        input logic [MAX_RO-1:0] mask,
        input int                n,
        input int                start
    );
        int         res;
        logic [5:0] idx;
        bit         found;
        res   = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_RO; i++) begin
            idx = 6'((start + i) & (n - 1));
            if (!found && i < n && mask[idx]) begin
                res   = int'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ro_mux_tree.sv
// Combinational log2(N_RO)-level 2:1 mux tree for oscillator selection.
// Select bit k picks between adjacent pairs of the level below it.
module ro_mux_tree #(
    parameter int N_RO  = 16,
    parameter int SEL_W = $clog2(N_RO)
) (
    input  logic [N_RO-1:0]  ro_in,
    input  logic [SEL_W-1:0] sel,
    output logic             ro_out
);

    for (genvar k = 0; k <= SEL_W; k++) begin : g_lvl
        logic [(N_RO>>k)-1:0] v;
        if (k == 0) begin : g_leaf
            assign v = ro_in;
        end else begin : g_mux
            for (genvar j = 0; j < (N_RO >> k); j++) begin : g_bit
                assign v[j] = sel[k-1] ? g_lvl[k-1].v[2*j+1]
                                       : g_lvl[k-1].v[2*j];
            end
        end
    end

    assign ro_out = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/ro_sel_sequencer.sv
// Ring-oscillator channel sequencer: registered select, gated output, settle and scan dwell.
// Define RO_PWR_GATE_EN to power only the ring being switched to or measured.
module ro_sel_sequencer #(
    parameter int N_RO     = 16,
    parameter int SEL_W    = $clog2(N_RO),
    parameter int SETTLE_W = 8,
    parameter int DWELL_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_RO-1:0]     RO_IN,
    output logic                RO_OUT,
    output logic [N_RO-1:0]     RO_EN,
    input  logic                REQ_VALID,
    input  logic [SEL_W-1:0]    REQ_SEL,
    output logic                REQ_READY,
    input  logic                SCAN_EN,
    input  logic [N_RO-1:0]     SCAN_MASK,
    input  logic [SETTLE_W-1:0] SETTLE_CYC,
    input  logic [DWELL_W-1:0]  DWELL_CYC,
    output logic [SEL_W-1:0]    CUR_SEL,
    output logic                SEL_VALID
);

    import pvt_sensor_pkg::*;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]    next_sel_q, next_sel_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                gate_q, gate_d;
    logic [DWELL_W:0]    dwell_inc;
    logic                dwell_done;
    logic                mask_any;
    logic                hs;
    logic [SEL_W-1:0]    first_ge;
    logic [SEL_W-1:0]    first_gt;
    logic                ro_mux;

    assign mask_any = |SCAN_MASK;
    assign first_ge = SEL_W'(next_set_bit(MAX_RO'(SCAN_MASK), N_RO,
                                          int'(cur_sel_q)));
    assign first_gt = SEL_W'(next_set_bit(MAX_RO'(SCAN_MASK), N_RO,
                                          int'(cur_sel_q) + 1));

    assign REQ_READY = !RST && !SCAN_EN
                    && (state_q == S_IDLE || state_q == S_ACTIVE);
    assign hs        = REQ_VALID && REQ_READY;

    // Dwell of 0 behaves as 1 so a scan always advances.
    assign dwell_inc  = {1'b0, dwell_q} + (DWELL_W+1)'(1);
    assign dwell_done = dwell_inc >= {1'b0, DWELL_CYC};

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        next_sel_d = next_sel_q;
        settle_d   = settle_q;
        dwell_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (SCAN_EN) begin
                    if (mask_any) begin
                        next_sel_d = first_ge;
                        state_d    = S_GATE;
                    end
                end else if (hs) begin
                    next_sel_d = REQ_SEL;
                    state_d    = S_GATE;
                end
            end
            S_GATE: begin
                state_d = S_SWITCH;
            end
            S_SWITCH: begin
                cur_sel_d = next_sel_q;
                settle_d  = (SETTLE_CYC == '0) ? SETTLE_W'(1) : SETTLE_CYC;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_ACTIVE;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            S_ACTIVE: begin
                if (SCAN_EN) begin
                    if (!dwell_done) begin
                        dwell_d = dwell_inc[DWELL_W-1:0];
                    end else if (mask_any) begin
                        next_sel_d = first_gt;
                        state_d    = S_GATE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (hs) begin
                    next_sel_d = REQ_SEL;
                    state_d    = S_GATE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        gate_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cur_sel_q  <= '0;
            next_sel_q <= '0;
            settle_q   <= '0;
            dwell_q    <= '0;
            gate_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            next_sel_q <= next_sel_d;
            settle_q   <= settle_d;
            dwell_q    <= dwell_d;
            gate_q     <= gate_d;
        end
    end

    ro_mux_tree #(
        .N_RO (N_RO)
    ) u_mux (
        .ro_in  (RO_IN),
        .sel    (cur_sel_q),
        .ro_out (ro_mux)
    );

    assign RO_OUT    = ro_mux & gate_q;
    assign SEL_VALID = gate_q;
    assign CUR_SEL   = cur_sel_q;

`ifdef RO_PWR_GATE_EN
    logic [N_RO-1:0] ro_en_q, ro_en_d;

    // New ring powers up on SWITCH so it runs through the settle window.
    always_comb begin
        ro_en_d = ro_en_q;
        if (state_q == S_SWITCH) begin
            ro_en_d = N_RO'(1) << next_sel_q;
        end
        if (state_d == S_IDLE) begin
            ro_en_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ro_en_q <= '0;
        end else begin
            ro_en_q <= ro_en_d;
        end
    end

    assign RO_EN = ro_en_q;
`else
    assign RO_EN = '1;
`endif

endmodule

// File: tb/tb_ro_sel_sequencer.sv
// Self-checking bench for ro_sel_sequencer: scenario tasks plus a channel scoreboard
// popped whenever SEL_VALID rises.
module tb_ro_sel_sequencer;

    localparam int N = 16;
`ifdef RO_PWR_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ro_in;
    logic [N-1:0] ro_en;
    logic [N-1:0] scan_mask;
    logic         ro_out;
    logic         req_valid;
    logic         req_ready;
    logic         scan_en;
    logic         sel_valid;
    logic [3:0]   req_sel;
    logic [3:0]   cur_sel;
    logic [7:0]   settle_cyc;
    logic [15:0]  dwell_cyc;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_v = 1'b0;

    always #5 clk = ~clk;

    ro_sel_sequencer dut (
        .CLK        (clk),
        .RST        (rst),
        .RO_IN      (ro_in),
        .RO_OUT     (ro_out),
        .RO_EN      (ro_en),
        .REQ_VALID  (req_valid),
        .REQ_SEL    (req_sel),
        .REQ_READY  (req_ready),
        .SCAN_EN    (scan_en),
        .SCAN_MASK  (scan_mask),
        .SETTLE_CYC (settle_cyc),
        .DWELL_CYC  (dwell_cyc),
        .CUR_SEL    (cur_sel),
        .SEL_VALID  (sel_valid)
    );

    function automatic logic [N-1:0] en_exp(input bit idle, input int ch);
        if (!GATED) return '1;
        if (idle) return '0;
        return N'(1) << ch;
    endfunction

    // Scoreboard: every activation must match the next expected channel.
    always @(negedge clk) begin
        int e;
        if (sel_valid === 1'b1 && prev_v !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: cur_sel=%0d, none expected", cur_sel);
            end else begin
                e = exp_q.pop_front();
                if (int'(cur_sel) !== e) begin
                    errors++;
                    $display("FAIL sb_channel: got %0d expected %0d", cur_sel, e);
                end
            end
        end
        prev_v = sel_valid;
    end

    task automatic test_reset;
        rst = 1'b1;
        ro_in = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready_in_reset: got %0d expected 0", req_ready);
        end
        checks++;
        if (ro_out !== 1'b0) begin
            errors++; $display("FAIL rst_ro_out_in_reset: got %0d expected 0", ro_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_sel !== 4'd0) begin
            errors++; $display("FAIL rst_cur_sel: got %0d expected 0", cur_sel);
        end
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++; $display("FAIL rst_sel_valid: got %0d expected 0", sel_valid);
        end
        checks++;
        if (ro_out !== 1'b0) begin
            errors++; $display("FAIL rst_ro_out: got %0d expected 0", ro_out);
        end
        checks++;
        if (ro_en !== en_exp(1'b1, 0)) begin
            errors++; $display("FAIL rst_ro_en: got %h expected %h", ro_en, en_exp(1'b1, 0));
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_idle_ready: got %0d expected 1", req_ready);
        end
    endtask

    task automatic test_manual;
        settle_cyc = 8'd4;
        req_valid = 1'b1;
        req_sel = 4'd9;
        exp_q.push_back(9);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            checks++;
            if (sel_valid !== (j == 8)) begin
                errors++; $display("FAIL manual_valid_t%0d: got %0d expected %0d", j - 1, sel_valid, j == 8);
            end
            checks++;
            if (cur_sel !== (j >= 3 ? 4'd9 : 4'd0)) begin
                errors++; $display("FAIL manual_sel_t%0d: got %0d expected %0d", j - 1, cur_sel, j >= 3 ? 9 : 0);
            end
        end
        ro_in = 16'h0200;
        #1;
        checks++;
        if (ro_out !== 1'b1) begin
            errors++; $display("FAIL manual_follow_hi: got %0d expected 1", ro_out);
        end
        ro_in = 16'hFDFF;
        #1;
        checks++;
        if (ro_out !== 1'b0) begin
            errors++; $display("FAIL manual_follow_lo: got %0d expected 0", ro_out);
        end
        checks++;
        if (ro_en !== en_exp(1'b0, 9)) begin
            errors++; $display("FAIL manual_ro_en: got %h expected %h", ro_en, en_exp(1'b0, 9));
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL manual_active_ready: got %0d expected 1", req_ready);
        end
    endtask

    task automatic test_switch_gating;
        int lo, bad, bad_rdy;
        req_valid = 1'b1;
        req_sel = 4'd3;
        exp_q.push_back(3);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && sel_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (sel_valid !== 1'b1) begin
            errors++; $display("FAIL gating_ch3_timeout: got %0d expected 1", sel_valid);
        end
        req_valid = 1'b1;
        req_sel = 4'd12;
        exp_q.push_back(12);
        lo = 0; bad = 0; bad_rdy = 0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && sel_valid !== 1'b1; k++) begin
            lo++;
            ro_in = 16'($urandom) | 16'h1008;
            #1;
            if (ro_out !== 1'b0) bad++;
            if (req_ready !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        checks++;
        if (lo != 7) begin
            errors++; $display("FAIL gating_low_cycles: got %0d expected 7", lo);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL gating_ro_out_leak: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++; $display("FAIL gating_ready_low: got %0d bad cycles expected 0", bad_rdy);
        end
        ro_in = 16'($urandom);
        #1;
        checks++;
        if (ro_out !== ro_in[12]) begin
            errors++; $display("FAIL gating_follow_ch12: got %0d expected %0d", ro_out, ro_in[12]);
        end
    endtask

    task automatic test_req_during_settle;
        int bad;
        req_valid = 1'b1;
        req_sel = 4'd1;
        exp_q.push_back(1);
        @(negedge clk);
        req_sel = 4'd7;
        exp_q.push_back(7);
        bad = 0;
        for (int k = 0; k < 20 && sel_valid !== 1'b1; k++) begin
            if (req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL held_req_ready_low: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL held_req_first_active: got %0d expected 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++; $display("FAIL held_req_accepted: sel_valid got %0d expected 0", sel_valid);
        end
        for (int k = 0; k < 20 && sel_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (sel_valid !== 1'b1) begin
            errors++; $display("FAIL held_req_ch7_timeout: got %0d expected 1", sel_valid);
        end
    endtask

    task automatic test_scan;
        int hi, lo, bad, bad_rdy;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        settle_cyc = 8'd2;
        dwell_cyc = 16'd10;
        scan_mask = 16'h8421;
        scan_en = 1'b1;
        exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(10);
        exp_q.push_back(15); exp_q.push_back(0);
        for (int k = 0; k < 30 && sel_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (sel_valid !== 1'b1) begin
            errors++; $display("FAIL scan_start_timeout: got %0d expected 1", sel_valid);
        end
        bad_rdy = 0;
        for (int v = 0; v < 4; v++) begin
            hi = 1;
            for (int k = 0; k < 30 && sel_valid === 1'b1; k++) begin
                if (req_ready !== 1'b0) bad_rdy++;
                @(negedge clk);
                if (sel_valid === 1'b1) hi++;
            end
            checks++;
            if (hi != 10) begin
                errors++; $display("FAIL scan_dwell_%0d: got %0d expected 10", v, hi);
            end
            lo = 1;
            for (int k = 0; k < 30 && sel_valid !== 1'b1; k++) begin
                @(negedge clk);
                if (sel_valid !== 1'b1) lo++;
            end
            checks++;
            if (lo != 5) begin
                errors++; $display("FAIL scan_gap_%0d: got %0d expected 5", v, lo);
            end
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++; $display("FAIL scan_ready_low: got %0d bad cycles expected 0", bad_rdy);
        end
        scan_en = 1'b0;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (sel_valid !== 1'b1 || cur_sel !== 4'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL scan_drop_hold: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL scan_drop_ready: got %0d expected 1", req_ready);
        end
    endtask

    task automatic test_scan_single;
        int hi, lo;
        scan_mask = 16'h0040;
        dwell_cyc = 16'd5;
        settle_cyc = 8'd1;
        scan_en = 1'b1;
        exp_q.push_back(6); exp_q.push_back(6); exp_q.push_back(6);
        for (int v = 0; v < 3; v++) begin
            hi = 1;
            for (int k = 0; k < 30 && sel_valid === 1'b1; k++) begin
                @(negedge clk);
                if (sel_valid === 1'b1) hi++;
            end
            if (v > 0) begin
                checks++;
                if (hi != 5) begin
                    errors++; $display("FAIL single_dwell_%0d: got %0d expected 5", v, hi);
                end
            end
            lo = 1;
            for (int k = 0; k < 30 && sel_valid !== 1'b1; k++) begin
                @(negedge clk);
                if (sel_valid !== 1'b1) lo++;
            end
            checks++;
            if (lo != 4) begin
                errors++; $display("FAIL single_gap_%0d: got %0d expected 4", v, lo);
            end
        end
    endtask

    task automatic test_scan_mask_zero;
        int hi, bad;
        scan_mask = '0;
        ro_in = '1;
        hi = 1;
        for (int k = 0; k < 30 && sel_valid === 1'b1; k++) begin
            @(negedge clk);
            if (sel_valid === 1'b1) hi++;
        end
        checks++;
        if (hi != 5) begin
            errors++; $display("FAIL mask0_finish_dwell: got %0d expected 5", hi);
        end
        bad = 0;
        repeat (20) begin
            if (sel_valid !== 1'b0 || ro_out !== 1'b0 || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mask0_idle: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (ro_en !== en_exp(1'b1, 0)) begin
            errors++; $display("FAIL mask0_ro_en: got %h expected %h", ro_en, en_exp(1'b1, 0));
        end
        scan_en = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL mask0_manual_ready: got %0d expected 1", req_ready);
        end
    endtask

    task automatic test_reset_active;
        settle_cyc = 8'd1;
        req_valid = 1'b1;
        req_sel = 4'd5;
        exp_q.push_back(5);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && sel_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (sel_valid !== 1'b1 || cur_sel !== 4'd5) begin
            errors++; $display("FAIL rst5_active: got valid=%0d sel=%0d expected 1/5", sel_valid, cur_sel);
        end
        ro_in = '1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ro_out !== 1'b0) begin
            errors++; $display("FAIL rst5_ro_out: got %0d expected 0", ro_out);
        end
        checks++;
        if (cur_sel !== 4'd0) begin
            errors++; $display("FAIL rst5_cur_sel: got %0d expected 0", cur_sel);
        end
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++; $display("FAIL rst5_sel_valid: got %0d expected 0", sel_valid);
        end
        checks++;
        if (ro_en !== en_exp(1'b1, 0)) begin
            errors++; $display("FAIL rst5_ro_en: got %h expected %h", ro_en, en_exp(1'b1, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        ro_in = '0;
        req_valid = 1'b0;
        req_sel = '0;
        scan_en = 1'b0;
        scan_mask = '0;
        settle_cyc = 8'd4;
        dwell_cyc = 16'd10;
        test_reset();
        test_manual();
        test_switch_gating();
        test_req_during_settle();
        test_scan();
        test_scan_single();
        test_scan_mask_zero();
        test_reset_active();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
